// File: rtl/drp_reconf_master.sv
// drp_reconf_master
//   Drives a PLL's Dynamic Reconfiguration Port through a session of
//   read-modify-write commands. START opens a session and holds the PLL in
//   reset. Each command reads a register, merges new bits under a keep-mask
//   and writes it back. After the command marked LAST, the PLL reset is
//   released and the block waits for LOCKED. Missing DRDY or LOCKED
//   responses end the session with a sticky ERROR.
//
// Ports
//   DCLK       in   clock, all state changes on its rising edge
//   RST_N      in   asynchronous active-low reset
//   START      in   begin a session (acted on in IDLE only)
//   CMD_VALID  in   command present on CMD_*
//   CMD_READY  out  command accepted this cycle (WAIT_CMD only)
//   CMD_ADDR   in   [6:0]  DRP register address
//   CMD_MASK   in   [15:0] 1 = keep current bit, 0 = take CMD_DATA bit
//   CMD_DATA   in   [15:0] new bit values
//   CMD_LAST   in   final command of the session
//   DADDR      out  [6:0]  DRP address
//   DEN        out  DRP enable strobe
//   DWE        out  DRP write enable
//   DI         out  [15:0] DRP write data
//   DO         in   [15:0] DRP read data
//   DRDY       in   DRP operation complete
//   PLL_RST    out  active-high PLL reset
//   LOCKED     in   PLL lock indication
//   BUSY       out  high outside IDLE
//   DONE       out  one-cycle pulse on successful session end
//   ERROR      out  sticky timeout flag, cleared by reset or accepted START
module drp_reconf_master #(
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic        DCLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [6:0]  CMD_ADDR,
  input  logic [15:0] CMD_MASK,
  input  logic [15:0] CMD_DATA,
  input  logic        CMD_LAST,
  output logic [6:0]  DADDR,
  output logic        DEN,
  output logic        DWE,
  output logic [15:0] DI,
  input  logic [15:0] DO,
  input  logic        DRDY,
  output logic        PLL_RST,
  input  logic        LOCKED,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR
);

  localparam int MAX_T = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
  localparam int CNT_W = $clog2(MAX_T + 1);
  localparam logic [CNT_W-1:0] DRDY_LAST = CNT_W'(DRDY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_CMD  = 3'd1,
    S_RD        = 3'd2,
    S_WAIT_RD   = 3'd3,
    S_WR        = 3'd4,
    S_WAIT_WR   = 3'd5,
    S_WAIT_LOCK = 3'd6
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             err_q, err_n;
  logic             done_q, done_n;
  logic             latch_cmd, latch_rd;

  logic [6:0]  addr_q;
  logic [15:0] mask_q;
  logic [15:0] data_q;
  logic        last_q;
  logic [15:0] rd_q;

  // Bits with mask=1 come from the register's current contents.
  function automatic logic [15:0] merge_bits(input logic [15:0] cur,
                                             input logic [15:0] mask,
                                             input logic [15:0] data);
    merge_bits = (cur & mask) | (data & ~mask);
  endfunction

  always_ff @(posedge DCLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= S_IDLE;
      cnt    <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      err_q  <= err_n;
      done_q <= done_n;
    end
  end

  // Command and read-back holding registers; their contents only reach the
  // outputs in RD/WR, so they need no reset.
  always_ff @(posedge DCLK) begin
    if (latch_cmd) begin
      addr_q <= CMD_ADDR;
      mask_q <= CMD_MASK;
      data_q <= CMD_DATA;
      last_q <= CMD_LAST;
    end
    if (latch_rd) begin
      rd_q <= DO;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = '0;
    err_n     = err_q;
    done_n    = 1'b0;
    latch_cmd = 1'b0;
    latch_rd  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (START) begin
          state_n = S_WAIT_CMD;
          err_n   = 1'b0;
        end
      end
      S_WAIT_CMD: begin
        if (CMD_VALID) begin
          latch_cmd = 1'b1;
          state_n   = S_RD;
        end
      end
      S_RD: state_n = S_WAIT_RD;
      S_WAIT_RD: begin
        if (DRDY) begin
          latch_rd = 1'b1;
          state_n  = S_WR;
        end else if (cnt == DRDY_LAST) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_WR: state_n = S_WAIT_WR;
      S_WAIT_WR: begin
        if (DRDY) begin
          state_n = last_q ? S_WAIT_LOCK : S_WAIT_CMD;
        end else if (cnt == DRDY_LAST) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (LOCKED) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else if (cnt == LOCK_LAST) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs decode straight from state so reset clears them asynchronously.
  assign CMD_READY = (state == S_WAIT_CMD);
  assign DEN       = (state == S_RD) || (state == S_WR);
  assign DWE       = (state == S_WR);
  assign DADDR     = DEN ? addr_q : 7'd0;
  assign DI        = (state == S_WR) ? merge_bits(rd_q, mask_q, data_q) : 16'd0;
  // PLL stays in reset from session start until the last write completes.
  assign PLL_RST   = (state == S_WAIT_CMD) || (state == S_RD) || (state == S_WAIT_RD) ||
                     (state == S_WR) || (state == S_WAIT_WR);
  assign BUSY      = (state != S_IDLE);
  assign DONE      = done_q;
  assign ERROR     = err_q;

endmodule
